rgmii_inband_status_decoder: RTL



---
 rtl/rgmii_pkg.sv | 31 +++
 rtl/inband_status_debounce.sv | 89 ++++++++
 rtl/rgmii_inband_status_decoder.sv | 133 +++++++++++++
 3 files changed

// File: rtl/rgmii_pkg.sv
// Shared definitions for the RGMII in-band status decoder:
// speed encodings, receive-gap FSM states and the status tuple.
package rgmii_pkg;

    localparam logic [1:0] SPEED_10   = 2'b00;
    localparam logic [1:0] SPEED_100  = 2'b01;
    localparam logic [1:0] SPEED_1000 = 2'b10;
    localparam logic [1:0] SPEED_RSVD = 2'b11;

    typedef enum logic [1:0] {
        FRAME  = 2'd0,
        GUARD  = 2'd1,
        SAMPLE = 2'd2
    } inband_state_t;

    typedef struct packed {
        logic       link;
        logic [1:0] speed;
        logic       duplex;
    } inband_status_t;

    // Map the rising-edge nibble seen during an inter-frame gap onto the status tuple.
    function automatic inband_status_t decode_nibble(input logic [3:0] nib);
        inband_status_t s;
        s.link   = nib[0];
        s.speed  = nib[2:1];
        s.duplex = nib[3];
        return s;
    endfunction

endpackage

// File: rtl/inband_status_debounce.sv
// Debounce and commit of in-band status samples. A tuple is committed once
// STABLE_CNT consecutive identical non-reserved samples have been seen.
// force_link_down drops the committed link and restarts the debounce.
module inband_status_debounce
    import rgmii_pkg::*;
#(
    parameter int STABLE_CNT = 4
) (
    input  logic           rx_mac_aclk,
    input  logic           sys_rst,
    input  logic           sample_valid,
    input  inband_status_t sample,
    input  logic           force_link_down,
    output inband_status_t status,
    output logic           status_valid,
    output logic           status_change
);

    localparam int             CW      = $clog2(STABLE_CNT + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(STABLE_CNT);

    inband_status_t cand_reg, cand_next;
    logic [CW-1:0]  cnt_reg, cnt_next;
    inband_status_t status_reg, status_next;
    logic           valid_reg, valid_next;
    logic           change_reg, change_next;
    logic           commit;

    // Candidate tracking and saturating agreement count; reserved speed breaks the run.
    always_comb begin
        cand_next = cand_reg;
        cnt_next  = cnt_reg;
        commit    = 1'b0;
        if (force_link_down) begin
            cnt_next = '0;
        end else if (sample_valid) begin
            if (sample.speed == SPEED_RSVD) begin
                cnt_next = '0;
            end else begin
                if (sample == cand_reg) begin
                    if (cnt_reg != CNT_MAX) begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end else begin
                    cand_next = sample;
                    cnt_next  = CW'(1);
                end
                commit = (cnt_next == CNT_MAX);
            end
        end
    end

    // Committed outputs: a commit or a forced link drop updates them, change flags real differences.
    always_comb begin
        status_next = status_reg;
        valid_next  = valid_reg;
        change_next = 1'b0;
        if (force_link_down) begin
            status_next.link = 1'b0;
            change_next      = status_reg.link;
        end else if (commit) begin
            status_next = cand_next;
            valid_next  = 1'b1;
            change_next = (cand_next != status_reg);
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge rx_mac_aclk or posedge sys_rst) begin
        if (sys_rst) begin
            cand_reg   <= '0;
            cnt_reg    <= '0;
            status_reg <= '0;
            valid_reg  <= 1'b0;
            change_reg <= 1'b0;
        end else begin
            cand_reg   <= cand_next;
            cnt_reg    <= cnt_next;
            status_reg <= status_next;
            valid_reg  <= valid_next;
            change_reg <= change_next;
        end
    end

    assign status        = status_reg;
    assign status_valid  = valid_reg;
    assign status_change = change_reg;

endmodule

// File: rtl/rgmii_inband_status_decoder.sv
// RGMII in-band status decoder top: input register, inter-frame-gap FSM and
// optional link timeout (enabled with the INBAND_TIMEOUT_EN macro).
module rgmii_inband_status_decoder
    import rgmii_pkg::*;
#(
    parameter int STABLE_CNT     = 4,
    parameter int IFG_GUARD      = 2,
    parameter int TIMEOUT_CYCLES = 1250000
) (
    input  logic       rx_mac_aclk,
    input  logic       sys_rst,
    input  logic [7:0] gmii_rxd,
    input  logic       gmii_rx_dv,
    input  logic       gmii_rx_er,
    output logic       inband_link_status,
    output logic [1:0] inband_clock_speed,
    output logic       inband_duplex_status,
    output logic       inband_status_valid,
    output logic       inband_status_change
);

    localparam logic [4:0] GUARD_LAST = 5'(IFG_GUARD);

    logic [3:0]     rxd_reg;
    logic           dv_reg;
    logic           er_reg;
    inband_state_t  state_reg, state_next;
    logic [3:0]     guard_cnt_reg, guard_cnt_next;
    logic           sample_valid;
    inband_status_t sample;
    logic           timeout_hit;
    inband_status_t status;

    // The falling-edge nibble carries nothing for status decoding.
    logic unused_rxd_hi;
    assign unused_rxd_hi = ^gmii_rxd[7:4];

    // Register the receive pins once; everything downstream uses these copies.
    always_ff @(posedge rx_mac_aclk or posedge sys_rst) begin
        if (sys_rst) begin
            rxd_reg <= '0;
            dv_reg  <= 1'b0;
            er_reg  <= 1'b0;
        end else begin
            rxd_reg <= gmii_rxd[3:0];
            dv_reg  <= gmii_rx_dv;
            er_reg  <= gmii_rx_er;
        end
    end

    // FSM and guard counter state.
    always_ff @(posedge rx_mac_aclk or posedge sys_rst) begin
        if (sys_rst) begin
            state_reg     <= GUARD;
            guard_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            guard_cnt_reg <= guard_cnt_next;
        end
    end

    // Next state: any dv/er activity means frame; idle cycles walk through the guard into sampling.
    always_comb begin
        state_next     = state_reg;
        guard_cnt_next = guard_cnt_reg;
        if (dv_reg || er_reg) begin
            state_next = FRAME;
        end else begin
            case (state_reg)
                FRAME: begin
                    guard_cnt_next = '0;
                    state_next     = (IFG_GUARD == 0) ? SAMPLE : GUARD;
                end
                GUARD: begin
                    if (({1'b0, guard_cnt_reg} + 5'd1) >= GUARD_LAST) begin
                        state_next = SAMPLE;
                    end else begin
                        guard_cnt_next = guard_cnt_reg + 4'd1;
                    end
                end
                SAMPLE:  state_next = SAMPLE;
                default: state_next = GUARD;
            endcase
        end
    end

    assign sample_valid = (state_reg == SAMPLE) && !dv_reg && !er_reg;
    assign sample       = decode_nibble(rxd_reg);

`ifdef INBAND_TIMEOUT_EN
    localparam int            TW     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES);

    logic [TW-1:0] to_cnt_reg;
    logic          good_sample;

    assign good_sample = sample_valid && (sample.speed != SPEED_RSVD);
    assign timeout_hit = !good_sample && (to_cnt_reg == TO_MAX - 1'b1);

    // Cycles since the last usable in-band sample, saturating at the timeout.
    always_ff @(posedge rx_mac_aclk or posedge sys_rst) begin
        if (sys_rst) begin
            to_cnt_reg <= '0;
        end else if (good_sample) begin
            to_cnt_reg <= '0;
        end else if (to_cnt_reg != TO_MAX) begin
            to_cnt_reg <= to_cnt_reg + 1'b1;
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
    assign timeout_hit        = 1'b0;
`endif

    inband_status_debounce #(
        .STABLE_CNT (STABLE_CNT)
    ) u_debounce (
        .rx_mac_aclk     (rx_mac_aclk),
        .sys_rst         (sys_rst),
        .sample_valid    (sample_valid),
        .sample          (sample),
        .force_link_down (timeout_hit),
        .status          (status),
        .status_valid    (inband_status_valid),
        .status_change   (inband_status_change)
    );

    assign inband_link_status   = status.link;
    assign inband_clock_speed   = status.speed;
    assign inband_duplex_status = status.duplex;

endmodule
